// File: rtl/fpu_sched_pkg.sv
// Shared FP scheduling types: FPU opcodes and the queued-op record.
package fpu_sched_pkg;

   localparam int unsigned PKG_LG_PRF_WIDTH = 4;
   localparam int unsigned PKG_LG_ROB_WIDTH = 4;
   localparam int unsigned PKG_LG_FCR_WIDTH = 4;

   typedef enum logic [4:0] {
      SP_ADD  = 5'd0,
      SP_SUB  = 5'd1,
      SP_MUL  = 5'd2,
      SP_DIV  = 5'd3,
      SP_SQRT = 5'd4,
      SP_CMP  = 5'd5,
      DP_ADD  = 5'd6,
      DP_SUB  = 5'd7,
      DP_MUL  = 5'd8,
      DP_DIV  = 5'd9,
      DP_SQRT = 5'd10,
      DP_CMP  = 5'd11,
      FP_FMA  = 5'd12,
      FP_I2F  = 5'd13,
      FP_F2I  = 5'd14
   } opcode_t;

   // Field widths track the package pointer widths; the scheduler's
   // pointer parameters are expected to match them.
   typedef struct packed {
      opcode_t                       opcode;
      logic [63:0]                   src_a;
      logic [63:0]                   src_b;
      logic [63:0]                   src_c;
      logic [7:0]                    src_fcr;
      logic [PKG_LG_ROB_WIDTH-1:0]   rob_ptr;
      logic [PKG_LG_PRF_WIDTH-1:0]   dst_ptr;
      logic [PKG_LG_FCR_WIDTH-1:0]   fcr_ptr;
      logic [2:0]                    fcr_sel;
   } fpu_sched_entry_t;

endpackage

// File: rtl/fpu_sched_queue.sv
// Circular FIFO of scheduled FP ops; pointers carry one extra wrap bit.
module fpu_sched_queue
   import fpu_sched_pkg::*;
#(
   parameter int LG_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 push,
   input  fpu_sched_entry_t     push_data,
   input  logic                 pop,
   output fpu_sched_entry_t     head_data,
   output logic [LG_DEPTH:0]    count
);

   localparam int DEPTH = 1 << LG_DEPTH;

   fpu_sched_entry_t     mem_q [DEPTH];
   logic [LG_DEPTH:0]    head_q, head_d;
   logic [LG_DEPTH:0]    tail_q, tail_d;
   logic                 full;
   logic                 empty;
   logic                 push_ok;
   logic                 pop_ok;

   assign full    = (head_q[LG_DEPTH] != tail_q[LG_DEPTH]) &&
                    (head_q[LG_DEPTH-1:0] == tail_q[LG_DEPTH-1:0]);
   assign empty   = (head_q == tail_q);
   assign push_ok = push && !full && !clear;
   assign pop_ok  = pop && !empty && !clear;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (clear) begin
         head_d = tail_q;
      end else begin
         if (push_ok) tail_d = tail_q + 1'b1;
         if (pop_ok)  head_d = head_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[tail_q[LG_DEPTH-1:0]] <= push_data;
   end

   assign head_data = mem_q[head_q[LG_DEPTH-1:0]];
   assign count     = tail_q - head_q;

endmodule

// File: rtl/fpu_sched.sv
// In-order FP issue scheduler: queues ready ops, issues one per cycle into
// the fixed-latency FPU, yields writeback slots and squashes flushed results.
module fpu_sched
   import fpu_sched_pkg::*;
#(
   parameter int LG_PRF_WIDTH = PKG_LG_PRF_WIDTH,
   parameter int LG_ROB_WIDTH = PKG_LG_ROB_WIDTH,
   parameter int LG_FCR_WIDTH = PKG_LG_FCR_WIDTH,
   parameter int FPU_LAT      = 2,
   parameter int LG_Q_DEPTH   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      enq_val,
   output logic                      enq_rdy,
   input  opcode_t                   enq_opcode,
   input  logic [63:0]               enq_src_a,
   input  logic [63:0]               enq_src_b,
   input  logic [63:0]               enq_src_c,
   input  logic [7:0]                enq_src_fcr,
   input  logic [LG_ROB_WIDTH-1:0]   enq_rob_ptr,
   input  logic [LG_PRF_WIDTH-1:0]   enq_dst_ptr,
   input  logic [LG_FCR_WIDTH-1:0]   enq_fcr_ptr,
   input  logic [2:0]                enq_fcr_sel,
   input  logic                      ext_wb_resv,
   output logic                      fpu_start,
   output opcode_t                   fpu_opcode,
   output logic [63:0]               fpu_src_a,
   output logic [63:0]               fpu_src_b,
   output logic [63:0]               fpu_src_c,
   output logic [7:0]                fpu_src_fcr,
   output logic [LG_ROB_WIDTH-1:0]   fpu_rob_ptr,
   output logic [LG_PRF_WIDTH-1:0]   fpu_dst_ptr,
   output logic [LG_FCR_WIDTH-1:0]   fpu_fcr_ptr,
   output logic [2:0]                fpu_fcr_sel,
   output logic                      wb_live,
   output logic [LG_Q_DEPTH:0]       q_count,
   output logic [31:0]               perf_issued,
   output logic [31:0]               perf_wb_stall
);

   localparam logic [LG_Q_DEPTH:0] Q_DEPTH = {1'b1, {LG_Q_DEPTH{1'b0}}};

   fpu_sched_entry_t     enq_entry;
   fpu_sched_entry_t     head_entry;
   fpu_sched_entry_t     fpu_entry_q, fpu_entry_d;
   logic                 fpu_start_q, fpu_start_d;
   logic [FPU_LAT-1:0]   live_q, live_d;
   logic [31:0]          perf_issued_q, perf_issued_d;
   logic [31:0]          perf_wb_stall_q, perf_wb_stall_d;
   logic                 enq_fire;
   logic                 issue;
   logic                 q_nonempty;
   logic                 q_clear;

   always_comb begin
      enq_entry         = '0;
      enq_entry.opcode  = enq_opcode;
      enq_entry.src_a   = enq_src_a;
      enq_entry.src_b   = enq_src_b;
      enq_entry.src_c   = enq_src_c;
      enq_entry.src_fcr = enq_src_fcr;
      enq_entry.rob_ptr = enq_rob_ptr;
      enq_entry.dst_ptr = enq_dst_ptr;
      enq_entry.fcr_ptr = enq_fcr_ptr;
      enq_entry.fcr_sel = enq_fcr_sel;
   end

   // Readiness uses this cycle's occupancy, so a same-cycle pop never
   // makes room for a push into a full queue.
   assign q_nonempty = (q_count != '0);
   assign enq_rdy    = (q_count != Q_DEPTH) && !flush && !reset;
   assign enq_fire   = enq_val && enq_rdy;
   assign issue      = q_nonempty && !ext_wb_resv && !flush && !reset;
   assign q_clear    = flush || reset;

   fpu_sched_queue #(
      .LG_DEPTH (LG_Q_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .clear     (q_clear),
      .push      (enq_fire),
      .push_data (enq_entry),
      .pop       (issue),
      .head_data (head_entry),
      .count     (q_count)
   );

   always_comb begin
      fpu_start_d     = issue;
      fpu_entry_d     = issue ? head_entry : fpu_entry_q;
      perf_issued_d   = perf_issued_q + {31'd0, fpu_start_q};
      perf_wb_stall_d = perf_wb_stall_q +
                        {31'd0, (q_nonempty && ext_wb_resv && !flush)};
      // Liveness shadows the FPU valid pipe; a flush kills every stage.
      live_d            = '0;
      live_d[FPU_LAT-1] = fpu_start_q && !flush;
      for (int i = 0; i < FPU_LAT - 1; i++) begin
         live_d[i] = live_q[i+1] && !flush;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fpu_start_q     <= 1'b0;
         fpu_entry_q     <= '0;
         live_q          <= '0;
         perf_issued_q   <= '0;
         perf_wb_stall_q <= '0;
      end else begin
         fpu_start_q     <= fpu_start_d;
         fpu_entry_q     <= fpu_entry_d;
         live_q          <= live_d;
         perf_issued_q   <= perf_issued_d;
         perf_wb_stall_q <= perf_wb_stall_d;
      end
   end

   assign fpu_start     = fpu_start_q;
   assign fpu_opcode    = fpu_entry_q.opcode;
   assign fpu_src_a     = fpu_entry_q.src_a;
   assign fpu_src_b     = fpu_entry_q.src_b;
   assign fpu_src_c     = fpu_entry_q.src_c;
   assign fpu_src_fcr   = fpu_entry_q.src_fcr;
   assign fpu_rob_ptr   = fpu_entry_q.rob_ptr;
   assign fpu_dst_ptr   = fpu_entry_q.dst_ptr;
   assign fpu_fcr_ptr   = fpu_entry_q.fcr_ptr;
   assign fpu_fcr_sel   = fpu_entry_q.fcr_sel;
   assign wb_live       = live_q[0];
   assign perf_issued   = perf_issued_q;
   assign perf_wb_stall = perf_wb_stall_q;

endmodule
